// File: rtl/mem_req_master_if.sv
// CPU load/store request port and block-RAM ren/wen/valid port bundled for mem_req_master.
interface mem_req_master_if #(
  parameter int unsigned AW = 9
);
  logic          cpu_req;
  logic          cpu_we;
  logic [1:0]    cpu_size;
  logic          cpu_unsigned;
  logic [63:0]   cpu_addr;
  logic [63:0]   cpu_wdata;
  logic          cpu_ready;
  logic          cpu_resp_valid;
  logic [63:0]   cpu_rdata;
  logic          cpu_err;
  logic [1:0]    cpu_err_cause;
  logic          ram_ren;
  logic          ram_wen;
  logic [AW-1:0] ram_addr;
  logic [63:0]   ram_wdata;
  logic [7:0]    ram_wmask;
  logic [63:0]   ram_rdata;
  logic          ram_valid;

  modport master (
    input  cpu_req, cpu_we, cpu_size, cpu_unsigned, cpu_addr, cpu_wdata,
    input  ram_rdata, ram_valid,
    output cpu_ready, cpu_resp_valid, cpu_rdata, cpu_err, cpu_err_cause,
    output ram_ren, ram_wen, ram_addr, ram_wdata, ram_wmask
  );

  modport slave (
    output cpu_req, cpu_we, cpu_size, cpu_unsigned, cpu_addr, cpu_wdata,
    output ram_rdata, ram_valid,
    input  cpu_ready, cpu_resp_valid, cpu_rdata, cpu_err, cpu_err_cause,
    input  ram_ren, ram_wen, ram_addr, ram_wdata, ram_wmask
  );
endinterface

// File: rtl/mem_req_master.sv
// Single-outstanding load/store initiator: checks alignment/range, drives the RAM handshake,
// lane-shifts stores and extracts/extends loads. One idle RAM cycle is kept between accesses.
module mem_req_master #(
  parameter int unsigned MEM_DEPTH = 4096,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic             clk,
  input  logic             rstn,
  mem_req_master_if.master bus
);
  localparam int unsigned AW = $clog2(MEM_DEPTH) - 3;
  localparam int unsigned AB = AW + 3;
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t        state_q, state_d;
  logic          ready_q, ready_d;
  logic          ren_q, ren_d;
  logic          wen_q, wen_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [63:0]   wdata_q, wdata_d;
  logic [7:0]    wmask_q, wmask_d;
  logic          resp_q, resp_d;
  logic [63:0]   rdata_q, rdata_d;
  logic          err_q, err_d;
  logic [1:0]    cause_q, cause_d;
  logic          we_q, we_d;
  logic [1:0]    size_q, size_d;
  logic          uns_q, uns_d;
  logic [2:0]    off_q, off_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          misaligned;
  logic          out_of_range;
  logic [7:0]    size_mask;
  logic [63:0]   sh;
  logic [63:0]   ld_data;

  // Request checks on the live CPU inputs
  always_comb begin
    misaligned = 1'b0;
    size_mask  = 8'hFF;
    case (bus.cpu_size)
      2'd0: begin misaligned = 1'b0;                 size_mask = 8'h01; end
      2'd1: begin misaligned = bus.cpu_addr[0];      size_mask = 8'h03; end
      2'd2: begin misaligned = |bus.cpu_addr[1:0];   size_mask = 8'h0F; end
      default: begin misaligned = |bus.cpu_addr[2:0]; size_mask = 8'hFF; end
    endcase
    out_of_range = |bus.cpu_addr[63:AB];
  end

  // Load lane extraction and extension from the latched request attributes
  always_comb begin
    sh = bus.ram_rdata >> {off_q, 3'b000};
    case (size_q)
      2'd0:    ld_data = {{56{sh[7]  & ~uns_q}}, sh[7:0]};
      2'd1:    ld_data = {{48{sh[15] & ~uns_q}}, sh[15:0]};
      2'd2:    ld_data = {{32{sh[31] & ~uns_q}}, sh[31:0]};
      default: ld_data = sh;
    endcase
  end

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    ren_d   = ren_q;
    wen_d   = wen_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    resp_d  = 1'b0;
    rdata_d = rdata_q;
    err_d   = err_q;
    cause_d = cause_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    off_d   = off_q;
    cnt_d   = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (bus.cpu_req) begin
          we_d   = bus.cpu_we;
          size_d = bus.cpu_size;
          uns_d  = bus.cpu_unsigned;
          off_d  = bus.cpu_addr[2:0];
          if (misaligned || out_of_range) begin
            state_d = S_RESP;
            resp_d  = 1'b1;
            err_d   = 1'b1;
            cause_d = misaligned ? 2'd1 : 2'd2;
            rdata_d = 64'd0;
          end else begin
            state_d = S_WAIT;
            ren_d   = ~bus.cpu_we;
            wen_d   = bus.cpu_we;
            addr_d  = bus.cpu_addr[AB-1:3];
            wdata_d = bus.cpu_wdata << {bus.cpu_addr[2:0], 3'b000};
            wmask_d = size_mask << bus.cpu_addr[2:0];
            cnt_d   = CW'(0);
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (bus.ram_valid) begin
          state_d = S_RESP;
          ren_d   = 1'b0;
          wen_d   = 1'b0;
          resp_d  = 1'b1;
          err_d   = 1'b0;
          cause_d = 2'd0;
          rdata_d = we_q ? 64'd0 : ld_data;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d = S_RESP;
          ren_d   = 1'b0;
          wen_d   = 1'b0;
          resp_d  = 1'b1;
          err_d   = 1'b1;
          cause_d = 2'd3;
          rdata_d = 64'd0;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        err_d   = 1'b0;
        cause_d = 2'd0;
        rdata_d = 64'd0;
      end
      default: state_d = S_IDLE;
    endcase

    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      ready_q <= 1'b1;
      ren_q   <= 1'b0;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 64'd0;
      wmask_q <= 8'd0;
      resp_q  <= 1'b0;
      rdata_q <= 64'd0;
      err_q   <= 1'b0;
      cause_q <= 2'd0;
      we_q    <= 1'b0;
      size_q  <= 2'd0;
      uns_q   <= 1'b0;
      off_q   <= 3'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      ren_q   <= ren_d;
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      resp_q  <= resp_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cause_q <= cause_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      off_q   <= off_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.cpu_ready      = ready_q;
  assign bus.cpu_resp_valid = resp_q;
  assign bus.cpu_rdata      = rdata_q;
  assign bus.cpu_err        = err_q;
  assign bus.cpu_err_cause  = cause_q;
  assign bus.ram_ren        = ren_q;
  assign bus.ram_wen        = wen_q;
  assign bus.ram_addr       = addr_q;
  assign bus.ram_wdata      = wdata_q;
  assign bus.ram_wmask      = wmask_q;
endmodule

// File: tb/tb_mem_req_master.sv
// Bench for mem_req_master: byte-array reference model, behavioural RAM, vector table,
// randomized accesses and hand-written reset / stray-valid sequences.
`timescale 1ns/1ps
module tb_mem_req_master;
  localparam int unsigned MEM_DEPTH = 4096;
  localparam int unsigned TIMEOUT   = 16;
  localparam int unsigned AW        = 9;
  localparam int unsigned WORDS     = MEM_DEPTH / 8;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  mem_req_master_if #(.AW(AW)) bus ();

  mem_req_master #(.MEM_DEPTH(MEM_DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int tests = 0;
  int fails = 0;

  logic [63:0] img     [WORDS];
  logic [63:0] ram     [WORDS];
  logic [7:0]  ref_mem [MEM_DEPTH];
  int          ram_lat;
  bit          ram_stall;
  bit          ram_force_valid;
  bit          load_img;
  int          lat_cnt;

  // Behavioural RAM: valid toggles while an enable is held, optional extra latency
  always @(posedge clk) begin
    logic [63:0] w;
    if (load_img) begin
      for (int i = 0; i < int'(WORDS); i++) ram[i] <= img[i];
      bus.ram_valid <= 1'b0;
      lat_cnt       <= 0;
    end else if (!rstn) begin
      bus.ram_valid <= 1'b0;
      lat_cnt       <= 0;
    end else begin
      if (bus.ram_wen) begin
        w = ram[bus.ram_addr];
        for (int i = 0; i < 8; i++)
          if (bus.ram_wmask[i]) w[i*8 +: 8] = bus.ram_wdata[i*8 +: 8];
        ram[bus.ram_addr] <= w;
      end
      if ((bus.ram_ren || bus.ram_wen) && !ram_stall && !bus.ram_valid) begin
        if (lat_cnt >= ram_lat) begin
          bus.ram_valid <= 1'b1;
          bus.ram_rdata <= ram[bus.ram_addr];
          lat_cnt       <= 0;
        end else begin
          bus.ram_valid <= 1'b0;
          bus.ram_rdata <= {$urandom, $urandom};
          lat_cnt       <= lat_cnt + 1;
        end
      end else begin
        bus.ram_valid <= ram_force_valid;
        bus.ram_rdata <= {$urandom, $urandom};
        lat_cnt       <= 0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: little-endian byte memory and the request rules
  function automatic void model(input bit we, input logic [1:0] size, input bit uns,
                                input logic [63:0] addr, input bit stall,
                                output bit err, output logic [1:0] cause,
                                output logic [63:0] rdata);
    int n = 1 << size;
    logic [63:0] v;
    err = 1'b0; cause = 2'd0; rdata = 64'd0;
    if ((addr % 64'(n)) != 64'd0) begin
      err = 1'b1; cause = 2'd1;
    end else if (addr >= 64'(MEM_DEPTH)) begin
      err = 1'b1; cause = 2'd2;
    end else if (stall) begin
      err = 1'b1; cause = 2'd3;
    end else if (!we) begin
      v = 64'd0;
      for (int i = 0; i < n; i++) v[i*8 +: 8] = ref_mem[int'(addr[11:0]) + i];
      if (!uns && n < 8 && v[8*n-1])
        for (int i = n; i < 8; i++) v[i*8 +: 8] = 8'hFF;
      rdata = v;
    end
  endfunction

  task automatic check_idle_zero(input string name);
    chk({name, " ready"}, 64'(bus.cpu_ready), 64'd1);
    chk({name, " ctl"}, 64'({bus.ram_ren, bus.ram_wen, bus.cpu_resp_valid, bus.cpu_err,
                               bus.cpu_err_cause}), 64'd0);
    chk({name, " rdata"}, bus.cpu_rdata, 64'd0);
    chk({name, " wdata"}, bus.ram_wdata, 64'd0);
    chk({name, " addr_mask"}, 64'({bus.ram_addr, bus.ram_wmask}), 64'd0);
  endtask

  task automatic access(input string name, input bit we, input logic [1:0] size, input bit uns,
                        input logic [63:0] addr, input logic [63:0] wd, input int lat,
                        input bit stall, input bit e_err, input logic [1:0] e_cause,
                        input logic [63:0] e_rdata);
    int k, n, off, exp_lat;
    bit got, en_seen, en_ok;
    logic [7:0]  e_mask;
    logic [63:0] e_wdata;
    n = 1 << size;
    off = int'(addr[2:0]);
    e_mask = 8'd0;
    e_wdata = 64'd0;
    for (int i = 0; i < 8; i++) begin
      if (i >= off && i < off + n) e_mask[i] = 1'b1;
      if (i >= off) e_wdata[i*8 +: 8] = wd[(i-off)*8 +: 8];
    end
    ram_lat = lat;
    ram_stall = stall;
    k = 0;
    while (!bus.cpu_ready && k < 50) begin tick(); k++; end
    chk({name, " ready_before"}, 64'(bus.cpu_ready), 64'd1);
    chk({name, " gap_before"}, 64'({bus.ram_ren, bus.ram_wen}), 64'd0);
    bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_size = size;
    bus.cpu_unsigned = uns; bus.cpu_addr = addr; bus.cpu_wdata = wd;
    tick();
    bus.cpu_req = 1'b0; bus.cpu_we = 1'($urandom); bus.cpu_size = 2'($urandom);
    bus.cpu_unsigned = 1'($urandom); bus.cpu_addr = {$urandom, $urandom};
    bus.cpu_wdata = {$urandom, $urandom};
    k = 1; got = 1'b0; en_seen = 1'b0; en_ok = 1'b1;
    while (!got && k <= 40) begin
      if (bus.cpu_resp_valid) got = 1'b1;
      else begin
        if (bus.ram_ren || bus.ram_wen) begin
          en_seen = 1'b1;
          if (bus.ram_ren !== !we || bus.ram_wen !== we || bus.ram_addr !== addr[11:3] ||
              bus.ram_wmask !== e_mask || (we && bus.ram_wdata !== e_wdata)) en_ok = 1'b0;
        end
        tick();
        k++;
      end
    end
    exp_lat = !e_err ? lat + 3 : (e_cause == 2'd3 ? int'(TIMEOUT) + 1 : 1);
    chk({name, " resp_seen"}, 64'(got), 64'd1);
    chk({name, " latency"}, 64'(k), 64'(exp_lat));
    chk({name, " err"}, 64'(bus.cpu_err), 64'(e_err));
    chk({name, " cause"}, 64'(bus.cpu_err_cause), 64'(e_cause));
    if (!e_err) chk({name, " rdata"}, bus.cpu_rdata, e_rdata);
    chk({name, " ram_access"}, 64'(en_seen), 64'(!(e_err && e_cause != 2'd3)));
    if (en_seen) chk({name, " ram_fields"}, 64'(en_ok), 64'd1);
    chk({name, " ready_in_resp"}, 64'(bus.cpu_ready), 64'd0);
    chk({name, " gap_in_resp"}, 64'({bus.ram_ren, bus.ram_wen}), 64'd0);
    tick();
    chk({name, " pulse_end"}, 64'(bus.cpu_resp_valid), 64'd0);
    chk({name, " ready_after"}, 64'(bus.cpu_ready), 64'd1);
    if (we && !e_err)
      for (int i = 0; i < n; i++) ref_mem[int'(addr[11:0]) + i] = wd[i*8 +: 8];
    ram_stall = 1'b0;
  endtask

  typedef struct packed {
    bit          we;
    logic [1:0]  size;
    bit          uns;
    logic [63:0] addr;
    logic [63:0] wd;
    logic [3:0]  lat;
    bit          stall;
    bit          err;
    logic [1:0]  cause;
    logic [63:0] rdata;
  } vec_t;

  vec_t tbl [12];

  initial begin
    bit          seen;
    bit          m_err;
    logic [1:0]  m_cause;
    logic [63:0] m_rdata;

    tbl[0]  = '{1'b0, 2'd0, 1'b0, 64'h87,    64'h0,    4'd0, 1'b0, 1'b0, 2'd0, 64'hFFFF_FFFF_FFFF_FF88};
    tbl[1]  = '{1'b0, 2'd1, 1'b1, 64'h82,    64'h0,    4'd1, 1'b0, 1'b0, 2'd0, 64'h4433};
    tbl[2]  = '{1'b0, 2'd2, 1'b0, 64'h84,    64'h0,    4'd0, 1'b0, 1'b0, 2'd0, 64'hFFFF_FFFF_8877_6655};
    tbl[3]  = '{1'b0, 2'd2, 1'b1, 64'h84,    64'h0,    4'd0, 1'b0, 1'b0, 2'd0, 64'h8877_6655};
    tbl[4]  = '{1'b1, 2'd1, 1'b0, 64'h86,    64'hABCD, 4'd0, 1'b0, 1'b0, 2'd0, 64'h0};
    tbl[5]  = '{1'b0, 2'd3, 1'b0, 64'h80,    64'h0,    4'd2, 1'b0, 1'b0, 2'd0, 64'hABCD_6655_4433_2211};
    tbl[6]  = '{1'b0, 2'd2, 1'b0, 64'h82,    64'h0,    4'd0, 1'b0, 1'b1, 2'd1, 64'h0};
    tbl[7]  = '{1'b0, 2'd0, 1'b0, 64'h1_0000, 64'h0,   4'd0, 1'b0, 1'b1, 2'd2, 64'h0};
    tbl[8]  = '{1'b0, 2'd3, 1'b0, 64'h80,    64'h0,    4'd0, 1'b1, 1'b1, 2'd3, 64'h0};
    tbl[9]  = '{1'b0, 2'd1, 1'b0, 64'h1_0001, 64'h0,   4'd0, 1'b0, 1'b1, 2'd1, 64'h0};
    tbl[10] = '{1'b0, 2'd0, 1'b1, 64'h87,    64'h0,    4'd3, 1'b0, 1'b0, 2'd0, 64'hAB};
    tbl[11] = '{1'b1, 2'd0, 1'b0, 64'h1_0000, 64'h5A,  4'd0, 1'b0, 1'b1, 2'd2, 64'h0};

    for (int i = 0; i < int'(WORDS); i++) img[i] = {$urandom, $urandom};
    img[16] = 64'h8877_6655_4433_2211;
    for (int b = 0; b < int'(MEM_DEPTH); b++) ref_mem[b] = img[b/8][8*(b%8) +: 8];

    ram_lat = 0; ram_stall = 1'b0; ram_force_valid = 1'b0; load_img = 1'b1;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_size = 2'd0; bus.cpu_unsigned = 1'b0;
    bus.cpu_addr = 64'd0; bus.cpu_wdata = 64'd0;
    rstn = 1'b0;
    tick(); tick();
    load_img = 1'b0;
    check_idle_zero("reset");
    rstn = 1'b1;
    tick();

    for (int i = 0; i < 12; i++)
      access($sformatf("vec%0d", i), tbl[i].we, tbl[i].size, tbl[i].uns, tbl[i].addr,
             tbl[i].wd, int'(tbl[i].lat), tbl[i].stall, tbl[i].err, tbl[i].cause, tbl[i].rdata);

    for (int t = 0; t < 80; t++) begin
      bit          we, uns, st;
      logic [1:0]  sz;
      logic [63:0] a, wd;
      int          lat, r;
      sz  = 2'($urandom_range(0, 3));
      we  = 1'($urandom_range(0, 1));
      uns = 1'($urandom_range(0, 1));
      lat = $urandom_range(0, 3);
      wd  = {$urandom, $urandom};
      a   = 64'($urandom_range(0, MEM_DEPTH - 1));
      a   = a & ~(64'(1 << sz) - 64'd1);
      r   = $urandom_range(0, 11);
      if (r == 0) a = a | 64'($urandom_range(1, 7));
      if (r == 1) a = a | (64'd1 << $urandom_range(12, 63));
      st  = (!we && r == 2);
      model(we, sz, uns, a, st, m_err, m_cause, m_rdata);
      access($sformatf("rnd%0d", t), we, sz, uns, a, wd, lat, st, m_err, m_cause, m_rdata);
    end

    // Stray ram_valid while idle must not produce a response
    ram_force_valid = 1'b1;
    seen = 1'b0;
    repeat (6) begin tick(); if (bus.cpu_resp_valid) seen = 1'b1; end
    ram_force_valid = 1'b0;
    chk("idle_valid no_resp", 64'(seen), 64'd0);
    tick(); tick();

    // Reset while waiting on the RAM drops the access silently
    ram_stall = 1'b1;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_size = 2'd3; bus.cpu_addr = 64'h80;
    tick();
    bus.cpu_req = 1'b0;
    tick(); tick();
    chk("rst_mid ren_before", 64'(bus.ram_ren), 64'd1);
    rstn = 1'b0;
    tick();
    check_idle_zero("rst_mid");
    rstn = 1'b1;
    ram_stall = 1'b0;
    seen = 1'b0;
    repeat (20) begin tick(); if (bus.cpu_resp_valid) seen = 1'b1; end
    chk("rst_mid no_resp", 64'(seen), 64'd0);

    model(1'b0, 2'd3, 1'b0, 64'h80, 1'b0, m_err, m_cause, m_rdata);
    access("after_rst", 1'b0, 2'd3, 1'b0, 64'h80, 64'd0, 0, 1'b0, m_err, m_cause, m_rdata);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
